// File: rtl/hilo_mac_ctrl.sv
// HI/LO multiply-accumulate sequencer: launches an external multiplier, folds products into HI/LO.
// Latency: MT ops write at T+1, MULT at D+1, MADD/MSUB at D+2 (one cycle earlier with HILO_FWD_EN).
// Backpressure: o_req_ready only in IDLE; no accept while i_flush is high. Optional macro: HILO_FWD_EN.
module hilo_mac_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    input  logic        i_flush,
    output logic        o_mul_start,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    output logic        o_mul_signed,
    input  logic        i_mul_done,
    input  logic [31:0] i_mul_lo,
    input  logic [31:0] i_mul_hi,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_wr_done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_ACC      = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'd6;
    localparam logic [2:0] OP_MTLO = 3'd7;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        signed_q, signed_d;
    logic [63:0] prod_q, prod_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        wr_done_q, wr_done_d;

    logic        req_acc;
    logic        req_is_mt;
    logic        op_is_acc;
    logic        op_is_sub;
    logic [63:0] acc_res;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdat, lo_wdat;

    // Request handshake: only IDLE accepts, and never alongside a flush
    assign req_acc   = i_req_valid && (state_q == S_IDLE) && !i_flush;
    assign req_is_mt = (i_req_op == OP_MTHI) || (i_req_op == OP_MTLO);
    // Only multiply ops are latched into op_q: 2..5 accumulate, 4..5 subtract
    assign op_is_acc = op_q[2] | op_q[1];
    assign op_is_sub = op_q[2];
    assign acc_res   = op_is_sub ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

    // State register and datapath flops, synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            signed_q  <= 1'b0;
            prod_q    <= 64'd0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            prod_q    <= prod_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_acc && !req_is_mt) state_d = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (i_mul_done) begin
                    // A flush racing the product discards it outright
                    state_d = (i_flush || !op_is_acc) ? S_IDLE : S_ACC;
                end else if (i_flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_ACC: state_d = S_IDLE;
            S_DRAIN: begin
                if (i_mul_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand latch, product capture and HI/LO write selection
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        prod_d   = prod_q;
        start_d  = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdat  = hi_q;
        lo_wdat  = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_acc) begin
                    if (i_req_op == OP_MTHI) begin
                        hi_we   = 1'b1;
                        hi_wdat = i_req_a;
                    end else if (i_req_op == OP_MTLO) begin
                        lo_we   = 1'b1;
                        lo_wdat = i_req_a;
                    end else begin
                        op_d     = i_req_op;
                        a_d      = i_req_a;
                        b_d      = i_req_b;
                        signed_d = ~i_req_op[0];
                        start_d  = 1'b1;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (i_mul_done && !i_flush) begin
                    if (op_is_acc) begin
                        prod_d = {i_mul_hi, i_mul_lo};
                    end else begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        hi_wdat = i_mul_hi;
                        lo_wdat = i_mul_lo;
                    end
                end
            end
            S_ACC: begin
                if (!i_flush) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_wdat = acc_res[63:32];
                    lo_wdat = acc_res[31:0];
                end
            end
            default: ;
        endcase
        hi_d      = hi_we ? hi_wdat : hi_q;
        lo_d      = lo_we ? lo_wdat : lo_q;
        busy_d    = (state_d != S_IDLE);
        wr_done_d = hi_we | lo_we;
    end

    // Output drive
    always_comb begin
        o_req_ready  = (state_q == S_IDLE);
        o_mul_start  = start_q;
        o_mul_a      = a_q;
        o_mul_b      = b_q;
        o_mul_signed = signed_q;
        o_busy       = busy_q;
`ifdef HILO_FWD_EN
        // Show the value being written in its write cycle
        o_hi      = hi_we ? hi_wdat : hi_q;
        o_lo      = lo_we ? lo_wdat : lo_q;
        o_wr_done = hi_we | lo_we;
`else
        o_hi      = hi_q;
        o_lo      = lo_q;
        o_wr_done = wr_done_q;
`endif
    end

endmodule

// File: tb/tb_hilo_mac_ctrl.sv
module tb_hilo_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_signed;
    logic        mul_done;
    logic [31:0] mul_lo, mul_hi;
    logic [31:0] hi, lo;
    logic        busy;
    logic        wr_done;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    hilo_mac_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_flush     (flush),
        .o_mul_start (mul_start),
        .o_mul_a     (mul_a),
        .o_mul_b     (mul_b),
        .o_mul_signed(mul_signed),
        .i_mul_done  (mul_done),
        .i_mul_lo    (mul_lo),
        .i_mul_hi    (mul_hi),
        .o_hi        (hi),
        .o_lo        (lo),
        .o_busy      (busy),
        .o_wr_done   (wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every o_wr_done pulse must match the next expected {HI,LO}
    always @(negedge clk) begin
        if (wr_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr_done actual={0x%0h,0x%0h} required=no write", hi, lo);
            end else begin
                chk("wr_result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v, input logic [63:0] exp);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = v;
        chk("mt_ready", {63'd0, req_ready}, 64'd1);
        exp_q.push_back(exp);
        tick();
        req_valid = 1'b0;
    endtask

    // Issue a multiply op, return product after lat cycles (done in cycle T+lat)
    task automatic mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic exp_signed,
                       input logic [63:0] prod, input logic [63:0] exp);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        chk("start_pulse", {63'd0, mul_start}, 64'd1);
        chk("mul_signed", {63'd0, mul_signed}, {63'd0, exp_signed});
        chk("mul_ops", {mul_a, mul_b}, {a, b});
        chk("busy_rise", {63'd0, busy}, 64'd1);
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("start_one_cycle", {63'd0, mul_start}, 64'd0);
        end
        mul_done = 1'b1;
        {mul_hi, mul_lo} = prod;
        exp_q.push_back(exp);
        tick();
        mul_done = 1'b0;
        if (op inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
            chk("busy_in_acc", {63'd0, busy}, 64'd1);
            tick();
        end
        chk("busy_drop", {63'd0, busy}, 64'd0);
        chk("ready_back", {63'd0, req_ready}, 64'd1);
        tick();
    endtask

    task automatic chk_reset_outs();
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_mul_ops", {mul_a, mul_b}, 64'd0);
        chk("rst_flags", {59'd0, mul_start, wr_done, busy, req_ready, mul_signed},
            {59'd0, 5'b00010});
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        flush     = 1'b0;
        mul_done  = 1'b0;
        mul_lo    = 32'd0;
        mul_hi    = 32'd0;
        tick();
        tick();
        chk_reset_outs();
        rst_n = 1'b1;
        tick();

        // Back-to-back MTHI / MTLO
        mt(3'd6, 32'h1234_5678, 64'h1234_5678_0000_0000);
        mt(3'd7, 32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        tick();
        chk("mt_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // MULT -1 * 2, done three cycles after accept
        mul(3'd0, 32'hFFFF_FFFF, 32'd2, 3, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);

        // MADDU carry from LO into HI
        mt(3'd6, 32'd0, 64'h0000_0000_FFFF_FFFE);
        mt(3'd7, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
        tick();
        mul(3'd3, 32'd1, 32'd1, 2, 1'b0, 64'd1, 64'h0000_0001_0000_0000);

        // MSUBU borrow, then wrap below zero
        mul(3'd5, 32'd1, 32'd1, 1, 1'b0, 64'd1, 64'h0000_0000_FFFF_FFFF);
        mt(3'd7, 32'd0, 64'd0);
        tick();
        mul(3'd5, 32'd1, 32'd1, 4, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);

        // MADD flushed two cycles before done: drains, no write
        req_valid = 1'b1; req_op = 3'd2; req_a = 32'd3; req_b = 32'd4;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_busy", {62'd0, busy, req_ready}, 64'b10);
        tick();
        chk("drain_hold_ops", {mul_a, mul_b}, {32'd3, 32'd4});
        mul_done = 1'b1; {mul_hi, mul_lo} = 64'd12;
        tick();
        mul_done = 1'b0;
        chk("drain_exit_ready", {63'd0, req_ready}, 64'd1);
        chk("drain_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        mul(3'd0, 32'd5, 32'd6, 1, 1'b1, 64'd30, 64'd30);

        // A request under flush is not accepted
        req_valid = 1'b1; req_op = 3'd6; req_a = 32'hDEAD_BEEF; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        tick();
        chk("flush_no_accept", {hi, lo}, 64'd30);

        // Reset during MUL_WAIT, then a stray done
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'h55; req_b = 32'h66;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mul_done = 1'b1; {mul_hi, mul_lo} = 64'h1111_2222_3333_4444;
        tick();
        mul_done = 1'b0;
        chk_reset_outs();
        tick();
        chk_reset_outs();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
